rs485_phy_if: RTL



---
 rtl/rs485_phy_if_pkg.sv | 26 ++
 rtl/rs485_phy_if_if.sv | 30 +++
 rtl/rs485_rx_filter.sv | 57 +++++
 rtl/rs485_phy_if.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rs485_phy_if_pkg.sv
// Shared definitions for the RS485 physical-side conditioning stage: turnaround FSM encoding,
// default line timing and counter sizing helpers.
package rs485_phy_if_pkg;

  typedef logic [1:0] ta_state_t;

  localparam ta_state_t ST_IDLE  = 2'd0;
  localparam ta_state_t ST_TX    = 2'd1;
  localparam ta_state_t ST_HOLD  = 2'd2;
  localparam ta_state_t ST_BLANK = 2'd3;

  localparam int unsigned DEF_CLK_FREQ   = 50000000;
  localparam int unsigned DEF_BAUD_RATE  = 115200;
  localparam int unsigned DEF_BREAK_BITS = 11;
  localparam int unsigned BIT_CYC        = DEF_CLK_FREQ / DEF_BAUD_RATE;
  localparam int unsigned BREAK_CYC      = DEF_BREAK_BITS * BIT_CYC;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned BRK_W  = cnt_width(BREAK_CYC);
  localparam int unsigned TCNT_W = cnt_width(BIT_CYC);

endpackage

// File: rtl/rs485_phy_if_if.sv
// Bundle of transceiver pins and slave-core side signals around rs485_phy_if.
// slave: the conditioning stage itself; master: the pins/core environment.
interface rs485_phy_if_if;

  logic        pin_rx;
  logic        pin_tx;
  logic        pin_de;
  logic        pin_re_n;
  logic        core_tx;
  logic        core_oe;
  logic        core_rx;
  logic        tx_active;
  logic        line_break;
  logic [15:0] glitch_cnt;
  logic        collision;
  logic [7:0]  collision_cnt;

  modport slave (
    input  pin_rx, core_tx, core_oe,
    output pin_tx, pin_de, pin_re_n, core_rx, tx_active, line_break, glitch_cnt,
           collision, collision_cnt
  );

  modport master (
    output pin_rx, core_tx, core_oe,
    input  pin_tx, pin_de, pin_re_n, core_rx, tx_active, line_break, glitch_cnt,
           collision, collision_cnt
  );

endinterface

// File: rtl/rs485_rx_filter.sv
// Two-flop synchronizer plus persistence filter for the RS485 receive line; short pulses are
// rejected and counted in a saturating glitch counter.
module rs485_rx_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rx_i,
  output logic        filt_o,
  output logic [15:0] glitch_cnt_o
);

  localparam logic [3:0] CntLast = 4'(FILT_LEN - 1);

  logic        s1_q, s2_q;
  logic        filt_q, filt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] glitch_q, glitch_d;

  always_comb begin
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != '0) begin
      // Level returned before persisting long enough: a rejected glitch.
      cnt_d = '0;
      if (glitch_q != 16'hFFFF) glitch_d = glitch_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      glitch_q <= '0;
    end else begin
      s1_q     <= rx_i;
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  assign filt_o       = filt_q;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: rtl/rs485_phy_if.sv
// RS485 pin conditioning: rx filtering, DE turnaround with echo blanking and break detection.
// Define RS485_ECHO_CHECK_EN to keep the receiver on while driving and flag echo collisions.
module rs485_phy_if
  import rs485_phy_if_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned HOLD_CYC   = (CLK_FREQ / BAUD_RATE) / 2,
  parameter int unsigned BLANK_CYC  = CLK_FREQ / BAUD_RATE,
  parameter int unsigned BREAK_BITS = DEF_BREAK_BITS
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  rs485_phy_if_if.slave bus_io
);

  localparam int unsigned BitCyc   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BreakCyc = BREAK_BITS * BitCyc;
  localparam int unsigned BrkW     = cnt_width(BreakCyc);
  localparam int unsigned TcntW    = cnt_width((HOLD_CYC > BLANK_CYC) ? HOLD_CYC : BLANK_CYC);

  logic filt;

  rs485_rx_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_rx_filter (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rx_i         (bus_io.pin_rx),
    .filt_o       (filt),
    .glitch_cnt_o (bus_io.glitch_cnt)
  );

  ta_state_t        state_q, state_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             blank;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: if (bus_io.core_oe) state_d = ST_TX;
      ST_TX: begin
        if (!bus_io.core_oe) begin
          state_d = ST_HOLD;
          tcnt_d  = TcntW'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (bus_io.core_oe) begin
          state_d = ST_TX;
        end else if (tcnt_q == '0) begin
          state_d = ST_BLANK;
          tcnt_d  = TcntW'(BLANK_CYC - 1);
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      ST_BLANK: begin
        if (bus_io.core_oe) begin
          state_d = ST_TX;
        end else if (tcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign blank = (state_q != ST_IDLE);

  logic pin_de_q, pin_tx_q, core_rx_q;
  logic [BrkW-1:0] brk_q, brk_d;
  logic line_break_q, line_break_d;

  // Break counter is held clear while blanked so our own transmission never looks like a break.
  always_comb begin
    brk_d        = brk_q;
    line_break_d = 1'b0;
    if (blank || filt) begin
      brk_d = '0;
    end else if (brk_q != BrkW'(BreakCyc)) begin
      brk_d        = brk_q + 1'b1;
      line_break_d = (brk_q == BrkW'(BreakCyc - 1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      pin_de_q     <= 1'b0;
      pin_tx_q     <= 1'b1;
      core_rx_q    <= 1'b1;
      brk_q        <= '0;
      line_break_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      pin_de_q     <= (state_d == ST_TX) || (state_d == ST_HOLD);
      pin_tx_q     <= (state_d == ST_TX) ? bus_io.core_tx : 1'b1;
      core_rx_q    <= blank ? 1'b1 : filt;
      brk_q        <= brk_d;
      line_break_q <= line_break_d;
    end
  end

  assign bus_io.pin_de     = pin_de_q;
  assign bus_io.pin_tx     = pin_tx_q;
  assign bus_io.core_rx    = core_rx_q;
  assign bus_io.tx_active  = blank;
  assign bus_io.line_break = line_break_q;

`ifdef RS485_ECHO_CHECK_EN
  localparam int unsigned DlyLen  = 2 + FILT_LEN;
  localparam int unsigned CollCyc = BitCyc / 4;
  localparam int unsigned MisW    = cnt_width(CollCyc);

  // Delay matches the pin-to-filt latency so the echo lines up with what we drove.
  logic [DlyLen-1:0] dly_q;
  logic [MisW-1:0]   mis_q, mis_d;
  logic              coll_q, coll_d;
  logic [7:0]        coll_cnt_q, coll_cnt_d;
  logic              mismatch;

  assign mismatch = (state_q == ST_TX) && (filt != dly_q[DlyLen-1]);

  always_comb begin
    mis_d      = '0;
    coll_d     = 1'b0;
    coll_cnt_d = coll_cnt_q;
    if (mismatch) begin
      mis_d = (mis_q == MisW'(CollCyc)) ? mis_q : mis_q + 1'b1;
      if (mis_q == MisW'(CollCyc - 1)) begin
        coll_d = 1'b1;
        if (coll_cnt_q != 8'hFF) coll_cnt_d = coll_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dly_q      <= '1;
      mis_q      <= '0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      dly_q      <= {dly_q[DlyLen-2:0], pin_tx_q};
      mis_q      <= mis_d;
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign bus_io.pin_re_n      = 1'b0;
  assign bus_io.collision     = coll_q;
  assign bus_io.collision_cnt = coll_cnt_q;
`else
  assign bus_io.pin_re_n      = pin_de_q;
  assign bus_io.collision     = 1'b0;
  assign bus_io.collision_cnt = 8'h00;
`endif

endmodule
